// File: rtl/legv8_pkg.sv
// LEGv8 opcode patterns, ALU enable codes and shared types for the ALU issue stage.
package legv8_pkg;

   localparam int unsigned OPCODE_W = 11;
   localparam int unsigned XZR      = 31;

   localparam logic [3:0] ALU_AND  = 4'b0110;
   localparam logic [3:0] ALU_ORR  = 4'b0100;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b1010;
   localparam logic [3:0] ALU_CBZ  = 4'b0111;
   localparam logic [3:0] ALU_CBNZ = 4'b0001;
   localparam logic [3:0] ALU_MOV  = 4'b1101;

   // Patterns are left-aligned; the matching care mask says how many leading bits count.
   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [10:0] OP_ADDI = 11'b10010001000;
   localparam logic [10:0] OP_SUBI = 11'b11010001000;
   localparam logic [10:0] OP_MOV  = 11'b11010010100;
   localparam logic [10:0] OP_CBZ  = 11'b10110100000;
   localparam logic [10:0] OP_CBNZ = 11'b10110101000;

   localparam logic [10:0] CARE_11 = 11'b11111111111;
   localparam logic [10:0] CARE_10 = 11'b11111111110;
   localparam logic [10:0] CARE_9  = 11'b11111111100;
   localparam logic [10:0] CARE_8  = 11'b11111111000;

   typedef struct packed {
      logic [3:0] enable;
      logic       illegal;
   } alu_ctrl_t;

   function automatic logic op_match(input logic [10:0] op, input logic [10:0] pat,
                                     input logic [10:0] care);
      return ((op ^ pat) & care) == 11'b0;
   endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational LEGv8 opcode to ALU enable decode; longest pattern wins.
module alu_ctrl_decode
   import legv8_pkg::*;
(
   input  logic [10:0] opcode,
   output alu_ctrl_t   ctrl
);

   always_comb begin
      ctrl.enable  = ALU_ADD;
      ctrl.illegal = 1'b0;
      if (op_match(opcode, OP_ADD, CARE_11) || op_match(opcode, OP_LDUR, CARE_11) ||
          op_match(opcode, OP_STUR, CARE_11)) begin
         ctrl.enable = ALU_ADD;
      end else if (op_match(opcode, OP_SUB, CARE_11)) begin
         ctrl.enable = ALU_SUB;
      end else if (op_match(opcode, OP_AND, CARE_11)) begin
         ctrl.enable = ALU_AND;
      end else if (op_match(opcode, OP_ORR, CARE_11)) begin
         ctrl.enable = ALU_ORR;
      end else if (op_match(opcode, OP_ADDI, CARE_10)) begin
         ctrl.enable = ALU_ADD;
      end else if (op_match(opcode, OP_SUBI, CARE_10)) begin
         ctrl.enable = ALU_SUB;
      end else if (op_match(opcode, OP_MOV, CARE_9)) begin
         ctrl.enable = ALU_MOV;
      end else if (op_match(opcode, OP_CBZ, CARE_8)) begin
         ctrl.enable = ALU_CBZ;
      end else if (op_match(opcode, OP_CBNZ, CARE_8)) begin
         ctrl.enable = ALU_CBNZ;
      end else begin
         ctrl.enable  = ALU_ADD;
         ctrl.illegal = 1'b1;
      end
   end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX pipeline register in front of the ALU: handshake, flush, opcode decode,
// operand forwarding and a saturating stall counter.
module alu_issue_stage
   import legv8_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_AW = 5,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   output logic              id_ready,
   input  logic [10:0]       id_opcode,
   input  logic [DATA_W-1:0] id_rdata1,
   input  logic [DATA_W-1:0] id_rdata2,
   input  logic [DATA_W-1:0] id_imm,
   input  logic              id_alusrc,
   input  logic [REG_AW-1:0] id_rn,
   input  logic [REG_AW-1:0] id_rm,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_regwrite,
   input  logic              flush,
   input  logic              ex_ready,
   input  logic              exmem_regwrite,
   input  logic [REG_AW-1:0] exmem_rd,
   input  logic [DATA_W-1:0] exmem_result,
   input  logic              memwb_regwrite,
   input  logic [REG_AW-1:0] memwb_rd,
   input  logic [DATA_W-1:0] memwb_result,
   output logic              ex_valid,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [3:0]        alu_enable,
   output logic [DATA_W-1:0] ex_store_data,
   output logic [REG_AW-1:0] ex_rd,
   output logic              ex_regwrite,
   output logic              ex_illegal,
   output logic [CNT_W-1:0]  stall_cnt
);

   alu_ctrl_t ctrl;

   logic              valid_q, valid_d;
   logic [3:0]        enable_q;
   logic              illegal_q;
   logic [DATA_W-1:0] rdata1_q, rdata2_q, imm_q;
   logic              alusrc_q;
   logic [REG_AW-1:0] rn_q, rm_q, rd_q;
   logic              regwrite_q;
   logic [CNT_W-1:0]  stall_q, stall_d;
   logic              capture;
   logic [DATA_W-1:0] fwd_rn, fwd_rm;

   alu_ctrl_decode u_decode (
      .opcode (id_opcode),
      .ctrl   (ctrl)
   );

   assign id_ready = !valid_q || ex_ready;
   assign capture  = id_valid && id_ready && !flush;

   always_comb begin
      valid_d = valid_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (capture) begin
         valid_d = 1'b1;
      end else if (ex_ready) begin
         valid_d = 1'b0;
      end
   end

   always_comb begin
      stall_d = stall_q;
      if (valid_q && !ex_ready && (stall_q != {CNT_W{1'b1}})) begin
         stall_d = stall_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q    <= 1'b0;
         enable_q   <= ALU_ADD;
         illegal_q  <= 1'b0;
         rdata1_q   <= '0;
         rdata2_q   <= '0;
         imm_q      <= '0;
         alusrc_q   <= 1'b0;
         rn_q       <= '0;
         rm_q       <= '0;
         rd_q       <= '0;
         regwrite_q <= 1'b0;
         stall_q    <= '0;
      end else begin
         valid_q <= valid_d;
         stall_q <= stall_d;
         if (capture) begin
            enable_q   <= ctrl.enable;
            illegal_q  <= ctrl.illegal;
            rdata1_q   <= id_rdata1;
            rdata2_q   <= id_rdata2;
            imm_q      <= id_imm;
            alusrc_q   <= id_alusrc;
            rn_q       <= id_rn;
            rm_q       <= id_rm;
            rd_q       <= id_rd;
            regwrite_q <= id_regwrite;
         end
      end
   end

   // XZR is never a forwarding target, so a write "to" it must not leak onto operands.
   function automatic logic [DATA_W-1:0] fwd(input logic [REG_AW-1:0] src,
                                             input logic [DATA_W-1:0] regdata);
      if (exmem_regwrite && (exmem_rd == src) && (exmem_rd != REG_AW'(XZR))) begin
         return exmem_result;
      end else if (memwb_regwrite && (memwb_rd == src) && (memwb_rd != REG_AW'(XZR))) begin
         return memwb_result;
      end
      return regdata;
   endfunction

   always_comb begin
      fwd_rn = fwd(rn_q, rdata1_q);
      fwd_rm = fwd(rm_q, rdata2_q);
   end

   assign ex_valid      = valid_q;
   assign alu_a         = fwd_rn;
   assign alu_b         = alusrc_q ? imm_q : fwd_rm;
   assign alu_enable    = enable_q;
   assign ex_store_data = fwd_rm;
   assign ex_rd         = rd_q;
   assign ex_regwrite   = regwrite_q && valid_q;
   assign ex_illegal    = illegal_q;
   assign stall_cnt     = stall_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: vector table plus stall/flush/saturation/reset sequences.
module tb_alu_issue_stage;

   localparam int unsigned CW = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid, id_ready;
   logic [10:0] id_opcode;
   logic [31:0] id_rdata1, id_rdata2, id_imm;
   logic        id_alusrc;
   logic [4:0]  id_rn, id_rm, id_rd;
   logic        id_regwrite, flush, ex_ready;
   logic        exmem_regwrite, memwb_regwrite;
   logic [4:0]  exmem_rd, memwb_rd;
   logic [31:0] exmem_result, memwb_result;
   logic        ex_valid;
   logic [31:0] alu_a, alu_b, ex_store_data;
   logic [3:0]  alu_enable;
   logic [4:0]  ex_rd;
   logic        ex_regwrite, ex_illegal;
   logic [CW-1:0] stall_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_issue_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(CW)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_opcode      (id_opcode),
      .id_rdata1      (id_rdata1),
      .id_rdata2      (id_rdata2),
      .id_imm         (id_imm),
      .id_alusrc      (id_alusrc),
      .id_rn          (id_rn),
      .id_rm          (id_rm),
      .id_rd          (id_rd),
      .id_regwrite    (id_regwrite),
      .flush          (flush),
      .ex_ready       (ex_ready),
      .exmem_regwrite (exmem_regwrite),
      .exmem_rd       (exmem_rd),
      .exmem_result   (exmem_result),
      .memwb_regwrite (memwb_regwrite),
      .memwb_rd       (memwb_rd),
      .memwb_result   (memwb_result),
      .ex_valid       (ex_valid),
      .alu_a          (alu_a),
      .alu_b          (alu_b),
      .alu_enable     (alu_enable),
      .ex_store_data  (ex_store_data),
      .ex_rd          (ex_rd),
      .ex_regwrite    (ex_regwrite),
      .ex_illegal     (ex_illegal),
      .stall_cnt      (stall_cnt)
   );

   typedef struct {
      logic [10:0] op;
      logic [4:0]  rn, rm, rd;
      logic [31:0] r1, r2, imm;
      logic        alusrc, rw;
      logic        ex_rw;
      logic [4:0]  ex_rd;
      logic [31:0] ex_res;
      logic        wb_rw;
      logic [4:0]  wb_rd;
      logic [31:0] wb_res;
      logic [31:0] exp_a, exp_b, exp_sd;
      logic [3:0]  exp_en;
      logic        exp_ill;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic drive_instr(input logic [10:0] op, input logic [4:0] rn, input logic [4:0] rm,
                              input logic [4:0] rd, input logic [31:0] r1,
                              input logic [31:0] r2, input logic [31:0] imm,
                              input logic alusrc, input logic rw);
      id_opcode   = op;
      id_rn       = rn;
      id_rm       = rm;
      id_rd       = rd;
      id_rdata1   = r1;
      id_rdata2   = r2;
      id_imm      = imm;
      id_alusrc   = alusrc;
      id_regwrite = rw;
   endtask

   task automatic fwd_off();
      exmem_regwrite = 1'b0;
      exmem_rd       = 5'd0;
      exmem_result   = 32'd0;
      memwb_regwrite = 1'b0;
      memwb_rd       = 5'd0;
      memwb_result   = 32'd0;
   endtask

   initial begin
      // op, rn, rm, rd, r1, r2, imm, alusrc, rw, exmem{rw,rd,res}, memwb{rw,rd,res},
      // exp a, b, store, enable, illegal
      vecs.push_back('{11'b10001011000, 1, 2, 3, 5, 7, 0, 0, 1, 0, 0, 0, 0, 0, 0,
                       5, 7, 7, 4'b0010, 0});
      vecs.push_back('{11'b11010001000, 1, 2, 4, 10, 6, 3, 1, 1, 0, 0, 0, 0, 0, 0,
                       10, 3, 6, 4'b1010, 0});
      vecs.push_back('{11'b10001011000, 1, 2, 5, 5, 7, 0, 0, 1, 1, 2, 9, 1, 2, 4,
                       5, 9, 9, 4'b0010, 0});
      vecs.push_back('{11'b10001011000, 1, 2, 5, 5, 7, 0, 0, 1, 1, 31, 9, 1, 2, 4,
                       5, 4, 4, 4'b0010, 0});
      vecs.push_back('{11'b10001011000, 31, 31, 6, 0, 0, 0, 0, 1, 1, 31, 9, 1, 31, 4,
                       0, 0, 0, 4'b0010, 0});
      vecs.push_back('{11'b10001011000, 1, 2, 7, 5, 7, 0, 0, 1, 0, 1, 9, 1, 1, 4,
                       4, 7, 7, 4'b0010, 0});
      vecs.push_back('{11'b10001010000, 1, 2, 8, 32'hF0, 32'h3C, 0, 0, 1, 0, 0, 0, 0, 0, 0,
                       32'hF0, 32'h3C, 32'h3C, 4'b0110, 0});
      vecs.push_back('{11'b10101010000, 3, 4, 9, 32'h11, 32'h22, 0, 0, 1, 0, 0, 0, 0, 0, 0,
                       32'h11, 32'h22, 32'h22, 4'b0100, 0});
      vecs.push_back('{11'b10110100101, 3, 4, 0, 32'h0, 32'h22, 32'h10, 1, 0, 0, 0, 0, 0, 0, 0,
                       32'h0, 32'h10, 32'h22, 4'b0111, 0});
      vecs.push_back('{11'b10110101000, 3, 4, 0, 32'h1, 32'h22, 32'h20, 1, 0, 0, 0, 0, 0, 0, 0,
                       32'h1, 32'h20, 32'h22, 4'b0001, 0});
      vecs.push_back('{11'b11010010111, 3, 4, 10, 32'h0, 32'h0, 32'hABCD, 1, 1, 0, 0, 0, 0, 0, 0,
                       32'h0, 32'hABCD, 32'h0, 4'b1101, 0});
      vecs.push_back('{11'b11111111111, 1, 2, 11, 32'h5, 32'h6, 0, 0, 1, 0, 0, 0, 0, 0, 0,
                       32'h5, 32'h6, 32'h6, 4'b0010, 1});
      vecs.push_back('{11'b11111000010, 1, 2, 12, 100, 6, 8, 1, 1, 0, 0, 0, 0, 0, 0,
                       100, 8, 6, 4'b0010, 0});
      vecs.push_back('{11'b11111000000, 1, 2, 13, 200, 55, 16, 1, 0, 0, 0, 0, 1, 2, 66,
                       200, 16, 66, 4'b0010, 0});
      vecs.push_back('{11'b10010001001, 1, 2, 14, 40, 6, 1, 1, 1, 0, 0, 0, 0, 0, 0,
                       40, 1, 6, 4'b0010, 0});
      vecs.push_back('{11'b11001011000, 1, 2, 15, 40, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                       40, 6, 6, 4'b1010, 0});
      vecs.push_back('{11'b10001011001, 1, 2, 16, 40, 6, 0, 0, 1, 0, 0, 0, 0, 0, 0,
                       40, 6, 6, 4'b0010, 1});

      rst_n    = 1'b1;
      id_valid = 1'b0;
      flush    = 1'b0;
      ex_ready = 1'b1;
      drive_instr(11'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      fwd_off();
      #1 rst_n = 1'b0;
      #1;
      chk("reset ex_valid", 32'(ex_valid), 32'd0);
      chk("reset alu_enable", 32'(alu_enable), 32'b0010);
      chk("reset stall_cnt", 32'(stall_cnt), 32'd0);
      chk("reset ex_illegal", 32'(ex_illegal), 32'd0);
      chk("reset ex_rd", 32'(ex_rd), 32'd0);
      chk("reset id_ready", 32'(id_ready), 32'd1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Table: one instruction per cycle, forward sources held through the check.
      for (int i = 0; i < vecs.size(); i++) begin
         drive_instr(vecs[i].op, vecs[i].rn, vecs[i].rm, vecs[i].rd, vecs[i].r1, vecs[i].r2,
                     vecs[i].imm, vecs[i].alusrc, vecs[i].rw);
         exmem_regwrite = vecs[i].ex_rw;
         exmem_rd       = vecs[i].ex_rd;
         exmem_result   = vecs[i].ex_res;
         memwb_regwrite = vecs[i].wb_rw;
         memwb_rd       = vecs[i].wb_rd;
         memwb_result   = vecs[i].wb_res;
         id_valid       = 1'b1;
         ex_ready       = 1'b1;
         @(negedge clk);
         chk($sformatf("v%0d ex_valid", i), 32'(ex_valid), 32'd1);
         chk($sformatf("v%0d alu_a", i), alu_a, vecs[i].exp_a);
         chk($sformatf("v%0d alu_b", i), alu_b, vecs[i].exp_b);
         chk($sformatf("v%0d store_data", i), ex_store_data, vecs[i].exp_sd);
         chk($sformatf("v%0d alu_enable", i), 32'(alu_enable), 32'(vecs[i].exp_en));
         chk($sformatf("v%0d ex_illegal", i), 32'(ex_illegal), 32'(vecs[i].exp_ill));
         chk($sformatf("v%0d ex_rd", i), 32'(ex_rd), 32'(vecs[i].rd));
         chk($sformatf("v%0d ex_regwrite", i), 32'(ex_regwrite), 32'(vecs[i].rw));
      end
      fwd_off();

      // Stall for three cycles, then flush with a new instruction offered.
      drive_instr(11'b10001011000, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 1'b0, 1'b1);
      id_valid = 1'b1;
      ex_ready = 1'b1;
      @(negedge clk);
      chk("stall start ex_valid", 32'(ex_valid), 32'd1);
      chk("stall start stall_cnt", 32'(stall_cnt), 32'd0);
      ex_ready = 1'b0;
      drive_instr(11'b11001011000, 5'd4, 5'd5, 5'd6, 32'd99, 32'd11, 32'd0, 1'b0, 1'b1);
      #1;
      chk("stall id_ready", 32'(id_ready), 32'd0);
      @(negedge clk);
      chk("stall held alu_a", alu_a, 32'd5);
      chk("stall held alu_enable", 32'(alu_enable), 32'b0010);
      @(negedge clk);
      @(negedge clk);
      chk("stall_cnt after 3", 32'(stall_cnt), 32'd3);
      chk("stall held ex_valid", 32'(ex_valid), 32'd1);
      chk("stall held alu_b", alu_b, 32'd7);
      chk("stall held ex_rd", 32'(ex_rd), 32'd3);
      exmem_regwrite = 1'b1;
      exmem_rd       = 5'd1;
      exmem_result   = 32'd77;
      #1;
      chk("stall refwd alu_a", alu_a, 32'd77);
      fwd_off();
      flush = 1'b1;
      #1;
      chk("flush id_ready unaffected", 32'(id_ready), 32'd0);
      @(negedge clk);
      chk("flush ex_valid", 32'(ex_valid), 32'd0);
      chk("flush stall_cnt", 32'(stall_cnt), 32'd4);
      chk("flush ex_regwrite", 32'(ex_regwrite), 32'd0);
      ex_ready = 1'b1;
      @(negedge clk);
      chk("flush drops incoming", 32'(ex_valid), 32'd0);
      flush    = 1'b0;
      id_valid = 1'b0;
      @(negedge clk);
      chk("after flush idle", 32'(ex_valid), 32'd0);

      // Capture then drain with no new instruction.
      id_valid = 1'b1;
      @(negedge clk);
      chk("drain capture alu_a", alu_a, 32'd99);
      chk("drain capture enable", 32'(alu_enable), 32'b1010);
      id_valid = 1'b0;
      @(negedge clk);
      chk("drain ex_valid", 32'(ex_valid), 32'd0);
      chk("drain ex_regwrite", 32'(ex_regwrite), 32'd0);

      // Saturation: counter continues from 4.
      id_valid = 1'b1;
      @(negedge clk);
      id_valid = 1'b0;
      ex_ready = 1'b0;
      repeat (10) @(negedge clk);
      chk("stall_cnt 14", 32'(stall_cnt), 32'd14);
      repeat (10) @(negedge clk);
      chk("stall_cnt saturated", 32'(stall_cnt), 32'd15);
      chk("saturate ex_valid", 32'(ex_valid), 32'd1);

      // Asynchronous reset in the middle of the stall.
      #2 rst_n = 1'b0;
      #1;
      chk("midreset ex_valid", 32'(ex_valid), 32'd0);
      chk("midreset alu_enable", 32'(alu_enable), 32'b0010);
      chk("midreset stall_cnt", 32'(stall_cnt), 32'd0);
      chk("midreset alu_a", alu_a, 32'd0);
      chk("midreset id_ready", 32'(id_ready), 32'd1);
      @(negedge clk);
      rst_n    = 1'b1;
      ex_ready = 1'b1;
      @(negedge clk);
      chk("post reset idle", 32'(ex_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
